// File: rtl/vlsu_txn_issuer.sv
// Turns page-bounded txn descriptors into AXI4 INCR AR/AW requests under a credit limit.
// Latency 1 cycle, no bubble; input stalls on held output or exhausted credits. Optional stats: VLSU_TXN_ISSUER_STATS_EN.
module vlsu_txn_issuer #(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned AxiDataWidth   = 128,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned TxnCntWidth    = 8,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  meta_valid_i,
    output logic                                  meta_ready_o,
    input  logic [IdWidth-1:0]                    req_id_i,
    input  logic                                  is_load_i,
    input  logic [AddrWidth-1:0]                  seg_base_addr_i,
    input  logic [TxnCntWidth-1:0]                txn_cnt_i,
    input  logic [TxnCntWidth-1:0]                txn_num_i,
    input  logic [13:0]                           lt_n_i,
    output logic                                  ar_valid_o,
    input  logic                                  ar_ready_i,
    output logic                                  aw_valid_o,
    input  logic                                  aw_ready_i,
    output logic [AddrWidth-2:0]                  ax_addr_o,
    output logic [7:0]                            ax_len_o,
    output logic [2:0]                            ax_size_o,
    output logic [IdWidth-1:0]                    ax_id_o,
    input  logic                                  rsp_done_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
`ifdef VLSU_TXN_ISSUER_STATS_EN
    output logic [31:0]                           stat_ar_cnt_o,
    output logic [31:0]                           stat_aw_cnt_o,
    output logic [31:0]                           stat_stall_cnt_o,
`endif
    output logic                                  idle_o
);

    localparam int unsigned LogB = $clog2(AxiDataWidth / 8);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [AddrWidth-1:0] page_base;
    logic [AddrWidth-1:0] start_nib;
    logic [12:0]          start_off;
    logic [13:0]          end_off;
    logic [13:0]          end_sum;
    logic [11:0]          bs;
    logic [12:0]          be;
    logic [13:0]          span;
    logic [7:0]           len_d;
    logic                 unused_bits;

    logic                 reg_vld_q;
    logic                 is_load_q;
    logic [CntW-1:0]      cnt_q;
    logic                 ax_rdy_sel;
    logic                 meta_hs;
    logic                 ax_hs;
    logic                 dec;

    // Later txns start on their own page; only the first one honours the in-page offset.
    assign page_base = {seg_base_addr_i[AddrWidth-1:13], 13'b0} + (AddrWidth'(txn_cnt_i) << 13);
    assign start_nib = (txn_cnt_i == '0) ? seg_base_addr_i : page_base;
    assign start_off = (txn_cnt_i == '0) ? seg_base_addr_i[12:0] : 13'd0;
    assign end_off   = (txn_cnt_i == txn_num_i) ? lt_n_i : 14'd8192;
    assign end_sum   = end_off + 14'd1;

    // Byte span measured page-relative; the page base is beat aligned so the math stays narrow.
    assign bs    = start_off[12:1];
    assign be    = end_sum[13:1];
    assign span  = 14'(bs[LogB-1:0]) + 14'(be) - 14'(bs) + 14'(AxiDataWidth / 8 - 1);
    assign len_d = 8'((span >> LogB) - 14'd1);

    assign unused_bits = ^{start_nib[0], start_off[0], end_sum[0]};

    assign ax_rdy_sel   = is_load_q ? ar_ready_i : aw_ready_i;
    assign ax_hs        = reg_vld_q & ax_rdy_sel;
    assign meta_ready_o = (~reg_vld_q | ax_rdy_sel) & (cnt_q < CntW'(MaxOutstanding));
    assign meta_hs      = meta_valid_i & meta_ready_o;
    assign dec          = rsp_done_i & (cnt_q != '0);

    assign ar_valid_o    = reg_vld_q & is_load_q;
    assign aw_valid_o    = reg_vld_q & ~is_load_q;
    assign ax_size_o     = 3'(LogB);
    assign outstanding_o = cnt_q;
    assign idle_o        = ~reg_vld_q & (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_vld_q <= 1'b0;
            is_load_q <= 1'b0;
            ax_addr_o <= '0;
            ax_len_o  <= '0;
            ax_id_o   <= '0;
        end else if (meta_hs) begin
            reg_vld_q <= 1'b1;
            is_load_q <= is_load_i;
            ax_addr_o <= start_nib[AddrWidth-1:1];
            ax_len_o  <= len_d;
            ax_id_o   <= req_id_i;
        end else if (ax_hs) begin
            reg_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (meta_hs && !dec) begin
            cnt_q <= cnt_q + CntW'(1);
        end else if (dec && !meta_hs) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

`ifdef VLSU_TXN_ISSUER_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_ar_cnt_o    <= '0;
            stat_aw_cnt_o    <= '0;
            stat_stall_cnt_o <= '0;
        end else begin
            if (ar_valid_o && ar_ready_i) stat_ar_cnt_o <= stat_ar_cnt_o + 32'd1;
            if (aw_valid_o && aw_ready_i) stat_aw_cnt_o <= stat_aw_cnt_o + 32'd1;
            if (meta_valid_i && !meta_ready_o) stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vlsu_txn_issuer.sv
// Directed bench for vlsu_txn_issuer: expected AR/AW requests queued at accept, checked at issue.
module tb_vlsu_txn_issuer;

    localparam int MaxOut = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        meta_valid = 1'b0;
    logic        meta_ready;
    logic [3:0]  req_id = '0;
    logic        is_load = 1'b0;
    logic [63:0] seg_base = '0;
    logic [7:0]  txn_cnt = '0;
    logic [7:0]  txn_num = '0;
    logic [13:0] lt_n = '0;
    logic        ar_valid, aw_valid;
    logic        ar_ready = 1'b1;
    logic        aw_ready = 1'b1;
    logic [62:0] ax_addr;
    logic [7:0]  ax_len;
    logic [2:0]  ax_size;
    logic [3:0]  ax_id;
    logic        rsp_done = 1'b0;
    logic [2:0]  outstanding;
    logic        idle;

    vlsu_txn_issuer #(
        .AddrWidth(64), .AxiDataWidth(128), .IdWidth(4), .TxnCntWidth(8), .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
        .req_id_i(req_id), .is_load_i(is_load), .seg_base_addr_i(seg_base),
        .txn_cnt_i(txn_cnt), .txn_num_i(txn_num), .lt_n_i(lt_n),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
        .ax_addr_o(ax_addr), .ax_len_o(ax_len), .ax_size_o(ax_size), .ax_id_o(ax_id),
        .rsp_done_i(rsp_done), .outstanding_o(outstanding), .idle_o(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld;
        logic [3:0]  id;
        logic [62:0] addr;
        logic [7:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a descriptor, waits (bounded) for acceptance, and queues the expected request.
    task automatic issue(input logic ld, input logic [3:0] id, input logic [63:0] base,
                         input logic [7:0] cnt, input logic [7:0] num, input logic [13:0] ltn,
                         input logic [62:0] ea, input logic [7:0] el);
        int n = 0;
        meta_valid = 1'b1; is_load = ld; req_id = id; seg_base = base;
        txn_cnt = cnt; txn_num = num; lt_n = ltn;
        @(negedge clk);
        while (!meta_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_within_bound", 64'(n < 50), 64'd1);
        exp_q.push_back('{ld, id, ea, el});
        @(posedge clk); #1;
        meta_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic done_cycles(input int k);
        rsp_done = 1'b1;
        repeat (k) @(posedge clk);
        #1 rsp_done = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ((ar_valid && ar_ready) || (aw_valid && aw_ready))) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_issue: queue size %0d, required nonzero, addr %0h", exp_q.size(), ax_addr);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_is_ar", 64'(ar_valid), 64'(e.ld));
                check("issue_is_aw", 64'(aw_valid), 64'(!e.ld));
                check("issue_addr", 64'(ax_addr), 64'(e.addr));
                check("issue_len", 64'(ax_len), 64'(e.len));
                check("issue_id", 64'(ax_id), 64'(e.id));
                check("issue_size", 64'(ax_size), 64'd4);
            end
        end
    end

    initial begin
        time t1, t2;

        // Reset state
        #1 rst = 1'b1;
        #3;
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_meta_ready", 64'(meta_ready), 64'd1);
        check("rst_addr", 64'(ax_addr), 64'd0);
        check("rst_len", 64'(ax_len), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single load txn, one cycle latency
        issue(1'b1, 4'h3, 64'h40, 8'd0, 8'd0, 14'h80, 63'h20, 8'd1);
        check("single_latency_ar_valid", 64'(ar_valid), 64'd1);
        check("single_outstanding", 64'(outstanding), 64'd1);
        check("single_not_idle", 64'(idle), 64'd0);
        drain();
        done_cycles(1);
        check("single_credit_back", 64'(outstanding), 64'd0);

        // Page split, back-to-back
        issue(1'b1, 4'h1, 64'h1FF0, 8'd0, 8'd1, 14'h10, 63'hFF8, 8'd0);
        t1 = $time;
        issue(1'b1, 4'h1, 64'h1FF0, 8'd1, 8'd1, 14'h10, 63'h1000, 8'd0);
        t2 = $time;
        check("split_no_bubble", 64'(t2 - t1), 64'd10);
        check("split_outstanding", 64'(outstanding), 64'd2);
        drain();
        done_cycles(2);

        // Full page middle store
        issue(1'b0, 4'h2, 64'h2100, 8'd1, 8'd2, 14'h100, 63'h2000, 8'd255);
        check("store_aw_valid", 64'(aw_valid), 64'd1);
        check("store_ar_quiet", 64'(ar_valid), 64'd0);
        drain();
        done_cycles(1);

        // Credits: fill, stall, release, simultaneous accept+done
        issue(1'b1, 4'h1, 64'h40,   8'd0, 8'd0, 14'h80,   63'h20,   8'd1);
        issue(1'b1, 4'h2, 64'h13,   8'd0, 8'd0, 14'h1234, 63'h9,    8'd145);
        issue(1'b1, 4'h3, 64'h3000, 8'd0, 8'd0, 14'h1001, 63'h1800, 8'd0);
        issue(1'b1, 4'h4, 64'h10,   8'd2, 8'd2, 14'h2000, 63'h2000, 8'd255);
        check("credit_full_count", 64'(outstanding), 64'd4);
        check("credit_full_ready_low", 64'(meta_ready), 64'd0);
        meta_valid = 1'b1; is_load = 1'b1; req_id = 4'h5; seg_base = 64'h1FF0;
        txn_cnt = 8'd1; txn_num = 8'd1; lt_n = 14'h10;
        repeat (3) begin
            @(negedge clk);
            check("credit_stall_ready", 64'(meta_ready), 64'd0);
            check("credit_stall_count", 64'(outstanding), 64'd4);
        end
        @(posedge clk); #1 rsp_done = 1'b1;
        @(posedge clk); #1 rsp_done = 1'b0;
        check("credit_ready_after_done", 64'(meta_ready), 64'd1);
        exp_q.push_back('{1'b1, 4'h5, 63'h1000, 8'd0});
        @(posedge clk); #1 meta_valid = 1'b0;
        check("credit_refill_count", 64'(outstanding), 64'd4);
        check("credit_released_issue", 64'(ar_valid), 64'd1);
        done_cycles(1);
        meta_valid = 1'b1; is_load = 1'b0; req_id = 4'h6; seg_base = 64'h2100;
        txn_cnt = 8'd1; txn_num = 8'd2; lt_n = 14'h100;
        rsp_done = 1'b1;
        check("simul_ready", 64'(meta_ready), 64'd1);
        exp_q.push_back('{1'b0, 4'h6, 63'h2000, 8'd255});
        @(posedge clk); #1;
        meta_valid = 1'b0; rsp_done = 1'b0;
        check("simul_count_kept", 64'(outstanding), 64'd3);
        check("simul_aw_valid", 64'(aw_valid), 64'd1);
        done_cycles(3);
        drain();
        check("credit_drained", 64'(outstanding), 64'd0);
        check("credit_idle", 64'(idle), 64'd1);

        // Backpressure on AR
        ar_ready = 1'b0;
        issue(1'b1, 4'h7, 64'h0000_1234_5678_0040, 8'd0, 8'd0, 14'h80, 63'h91A_2B3C_0020, 8'd1);
        meta_valid = 1'b1; is_load = 1'b1; req_id = 4'h8; seg_base = 64'h10;
        txn_cnt = 8'd2; txn_num = 8'd2; lt_n = 14'h2000;
        repeat (5) begin
            @(negedge clk);
            check("bp_ar_valid", 64'(ar_valid), 64'd1);
            check("bp_addr_stable", 64'(ax_addr), 64'h91A_2B3C_0020);
            check("bp_len_stable", 64'(ax_len), 64'd1);
            check("bp_ready_low", 64'(meta_ready), 64'd0);
        end
        @(posedge clk); #1 ar_ready = 1'b1;
        issue(1'b1, 4'h8, 64'h10, 8'd2, 8'd2, 14'h2000, 63'h2000, 8'd255);
        drain();
        check("bp_outstanding", 64'(outstanding), 64'd2);
        done_cycles(2);

        // Async reset with a held request and three credits in use
        issue(1'b1, 4'h9, 64'h40, 8'd0, 8'd0, 14'h80, 63'h20, 8'd1);
        issue(1'b1, 4'hA, 64'h40, 8'd0, 8'd0, 14'h80, 63'h20, 8'd1);
        @(posedge clk); #1 ar_ready = 1'b0;
        issue(1'b1, 4'hB, 64'h40, 8'd0, 8'd0, 14'h80, 63'h20, 8'd1);
        check("pre_rst_count", 64'(outstanding), 64'd3);
        check("pre_rst_ar_valid", 64'(ar_valid), 64'd1);
        check("pre_rst_queue", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        #2 rst = 1'b1;
        #1;
        check("arst_ar_valid", 64'(ar_valid), 64'd0);
        check("arst_outstanding", 64'(outstanding), 64'd0);
        check("arst_idle", 64'(idle), 64'd1);
        check("arst_meta_ready", 64'(meta_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; ar_ready = 1'b1;

        // Recovery after reset
        issue(1'b0, 4'hC, 64'h40, 8'd0, 8'd0, 14'h80, 63'h20, 8'd1);
        drain();
        check("recover_outstanding", 64'(outstanding), 64'd1);
        done_cycles(1);
        check("recover_idle", 64'(idle), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
